// File: rtl/brat_checkpoint_pkg.sv
// Shared rename-stage sizing and the branch checkpoint slot record.
// Imported by the BRAT top and its per-slot storage.
package brat_checkpoint_pkg;

  localparam int ARCH_REGFILE_SIZE = 32;
  localparam int PHYS_REGFILE_SIZE = 64;
  localparam int PHYS_REG_TAG      = $clog2(PHYS_REGFILE_SIZE);
  localparam int ARCH_REG_TAG      = $clog2(ARCH_REGFILE_SIZE);
  localparam int BRAT_SIZE         = 4;
  localparam int BRAT_IDX_W        = $clog2(BRAT_SIZE);
  localparam int BRAT_CNT_W        = BRAT_IDX_W + 1;

  typedef logic [BRAT_IDX_W-1:0] BRAT_IDX;
  typedef logic [ARCH_REGFILE_SIZE-1:0][PHYS_REG_TAG-1:0] rat_map_t;
  typedef logic [ARCH_REGFILE_SIZE-1:0] rat_ready_t;

  typedef struct packed {
    rat_map_t   value;
    rat_ready_t ready;
    logic       valid;
    logic       resolved;
  } BRAT_ENTRY;

  // Per-register compare of a map against one broadcast tag.
  function automatic rat_ready_t cdb_hits(input rat_map_t map, input logic hit_valid,
                                          input logic [PHYS_REG_TAG-1:0] tag);
    rat_ready_t hits;
    for (int i = 0; i < ARCH_REGFILE_SIZE; i++) begin
      hits[i] = hit_valid && (map[i] == tag);
    end
    return hits;
  endfunction

endpackage

// File: rtl/brat_checkpoint_entry.sv
// One checkpoint slot: snapshot write, CDB ready-bit tracking and a read
// port whose ready bits already include this cycle's broadcast.
module brat_checkpoint_entry
  import brat_checkpoint_pkg::*;
(
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    write,
  input  rat_map_t                write_value,
  input  rat_ready_t              write_ready,
  input  logic                    clear,
  input  logic                    set_resolved,
  input  logic                    cdb_valid,
  input  logic [PHYS_REG_TAG-1:0] cdb_tag,
  output logic                    valid,
  output logic                    resolved,
  output rat_map_t                value,
  output rat_ready_t              ready_fwd
);

  BRAT_ENTRY  slot;
  rat_ready_t stored_hits;
  rat_ready_t write_hits;

  assign stored_hits = cdb_hits(slot.value, cdb_valid, cdb_tag);
  assign write_hits  = cdb_hits(write_value, cdb_valid, cdb_tag);

  assign valid     = slot.valid;
  assign resolved  = slot.resolved;
  assign value     = slot.value;
  assign ready_fwd = slot.ready | stored_hits;

  always_ff @(posedge clock) begin
    if (!reset) begin
      slot <= '0;
    end else if (write) begin
      slot.value    <= write_value;
      slot.ready    <= write_ready | write_hits;
      slot.valid    <= 1'b1;
      slot.resolved <= 1'b0;
    end else if (clear) begin
      slot.valid    <= 1'b0;
      slot.resolved <= 1'b0;
    end else if (slot.valid) begin
      slot.ready <= slot.ready | stored_hits;
      if (set_resolved) slot.resolved <= 1'b1;
    end
  end

endmodule

// File: rtl/brat_checkpoint.sv
// Branch checkpoint store: in-order ring of RAT snapshots, freed when resolved
// correct, restored and squashed (with all younger slots) on a mispredict.
module brat_checkpoint
  import brat_checkpoint_pkg::*;
(
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    stall,
  input  logic                    take_valid,
  input  rat_map_t                rat_value_in,
  input  rat_ready_t              rat_ready_in,
  output logic                    take_ack,
  output BRAT_IDX                 take_id,
  output logic                    full,
  output logic [BRAT_CNT_W-1:0]   count,
  output logic [BRAT_SIZE-1:0]    live_mask,
  input  logic                    resolve_valid,
  input  BRAT_IDX                 resolve_id,
  input  logic                    resolve_mispredict,
  input  logic                    cdb_valid,
  input  logic [PHYS_REG_TAG-1:0] cdb_tag,
  output logic                    checkpoint_write,
  output rat_map_t                checkpoint_rat_value_out,
  output rat_ready_t              checkpoint_rat_ready_out,
  output logic [BRAT_SIZE-1:0]    squash_mask
);

  BRAT_IDX                     head;
  BRAT_IDX                     tail;
  BRAT_IDX                     mis_dist;
  BRAT_IDX                     age [BRAT_SIZE];
  logic [BRAT_SIZE-1:0]        live;
  logic [BRAT_SIZE-1:0]        slot_resolved;
  rat_map_t                    ent_value [BRAT_SIZE];
  rat_ready_t                  ent_ready [BRAT_SIZE];
  logic                        mis;
  logic                        res_ok;
  logic                        pop;

  assign mis    = reset && resolve_valid && resolve_mispredict && live[resolve_id];
  assign res_ok = reset && resolve_valid && !resolve_mispredict && live[resolve_id];

  // Mispredicting a stale resolved head must not also pop it.
  assign pop = reset && live[head] &&
               (slot_resolved[head] || (res_ok && resolve_id == head)) &&
               !(mis && resolve_id == head);

  assign full      = (count == BRAT_CNT_W'(BRAT_SIZE));
  assign take_ack  = reset && take_valid && !stall && !full && !mis;
  assign take_id   = tail;
  assign live_mask = live;
  assign mis_dist  = resolve_id - head;

  genvar k;
  generate
    for (k = 0; k < BRAT_SIZE; k++) begin : g_slot
      // Age relative to head orders slots oldest-first across the wrap.
      assign age[k]         = BRAT_IDX'(k) - head;
      assign squash_mask[k] = mis && live[k] && (age[k] >= mis_dist);

      brat_checkpoint_entry u_entry (
        .clock        (clock),
        .reset        (reset),
        .write        (take_ack && tail == BRAT_IDX'(k)),
        .write_value  (rat_value_in),
        .write_ready  (rat_ready_in),
        .clear        (squash_mask[k] || (pop && head == BRAT_IDX'(k))),
        .set_resolved (res_ok && resolve_id == BRAT_IDX'(k)),
        .cdb_valid    (cdb_valid),
        .cdb_tag      (cdb_tag),
        .valid        (live[k]),
        .resolved     (slot_resolved[k]),
        .value        (ent_value[k]),
        .ready_fwd    (ent_ready[k])
      );
    end
  endgenerate

  always_comb begin
    checkpoint_write         = mis;
    checkpoint_rat_value_out = '0;
    checkpoint_rat_ready_out = '0;
    if (mis) begin
      checkpoint_rat_value_out = ent_value[resolve_id];
      checkpoint_rat_ready_out = ent_ready[resolve_id];
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (pop) head <= head + 1'b1;
      if (mis) begin
        tail  <= resolve_id;
        count <= {1'b0, mis_dist} - BRAT_CNT_W'(pop);
      end else begin
        if (take_ack) tail <= tail + 1'b1;
        count <= count + BRAT_CNT_W'(take_ack) - BRAT_CNT_W'(pop);
      end
    end
  end

`ifdef DEBUG_MODE
  always_ff @(posedge clock) begin
    if (reset && resolve_valid) begin
      assert (live[resolve_id])
        else $error("brat_checkpoint: resolve of non-live slot %0d", resolve_id);
    end
  end
`endif

endmodule

// File: tb/tb_brat_checkpoint.sv
// Randomized and directed checks of brat_checkpoint against an age-ordered
// queue model of the live checkpoints.
module tb_brat_checkpoint;
  import brat_checkpoint_pkg::*;

  logic                    clock = 1'b0;
  logic                    reset;
  logic                    stall;
  logic                    take_valid;
  rat_map_t                rat_value_in;
  rat_ready_t              rat_ready_in;
  logic                    take_ack;
  BRAT_IDX                 take_id;
  logic                    full;
  logic [BRAT_CNT_W-1:0]   count;
  logic [BRAT_SIZE-1:0]    live_mask;
  logic                    resolve_valid;
  BRAT_IDX                 resolve_id;
  logic                    resolve_mispredict;
  logic                    cdb_valid;
  logic [PHYS_REG_TAG-1:0] cdb_tag;
  logic                    checkpoint_write;
  rat_map_t                checkpoint_rat_value_out;
  rat_ready_t              checkpoint_rat_ready_out;
  logic [BRAT_SIZE-1:0]    squash_mask;

  brat_checkpoint dut (
    .clock                    (clock),
    .reset                    (reset),
    .stall                    (stall),
    .take_valid               (take_valid),
    .rat_value_in             (rat_value_in),
    .rat_ready_in             (rat_ready_in),
    .take_ack                 (take_ack),
    .take_id                  (take_id),
    .full                     (full),
    .count                    (count),
    .live_mask                (live_mask),
    .resolve_valid            (resolve_valid),
    .resolve_id               (resolve_id),
    .resolve_mispredict       (resolve_mispredict),
    .cdb_valid                (cdb_valid),
    .cdb_tag                  (cdb_tag),
    .checkpoint_write         (checkpoint_write),
    .checkpoint_rat_value_out (checkpoint_rat_value_out),
    .checkpoint_rat_ready_out (checkpoint_rat_ready_out),
    .squash_mask              (squash_mask)
  );

  always #5 clock = ~clock;

  typedef struct {
    int         slot;
    rat_map_t   val;
    rat_ready_t rdy;
    bit         resolved;
  } rec_t;

  rec_t       q[$];
  int         mtail;
  int         n_checks = 0;
  int         n_pass = 0;
  logic       obs_ack;
  BRAT_IDX    obs_take_id;
  logic       obs_write;
  rat_map_t   obs_val;
  rat_ready_t obs_rdy;
  logic [BRAT_SIZE-1:0] obs_squash;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
  endtask

  function automatic rat_ready_t match(input rat_map_t m, input logic v, input logic [PHYS_REG_TAG-1:0] t);
    rat_ready_t r;
    for (int i = 0; i < ARCH_REGFILE_SIZE; i++) r[i] = v && (m[i] == t);
    return r;
  endfunction

  task automatic idle();
    reset = 1'b1; stall = 1'b0; take_valid = 1'b0;
    rat_value_in = '0; rat_ready_in = '0;
    resolve_valid = 1'b0; resolve_id = '0; resolve_mispredict = 1'b0;
    cdb_valid = 1'b0; cdb_tag = '0;
  endtask

  // Check combinational and registered outputs against the model, then take the edge.
  task automatic cycle();
    int                   p;
    bit                   e_mis, e_ok, e_ack, e_pop;
    logic [BRAT_SIZE-1:0] e_live, e_sq;
    rat_map_t             e_val;
    rat_ready_t           e_rdy;
    rec_t                 r;
    #1;
    p = -1;
    e_live = '0;
    foreach (q[i]) begin
      e_live[q[i].slot] = 1'b1;
      if (q[i].slot == int'(resolve_id)) p = i;
    end
    e_mis = reset && resolve_valid && resolve_mispredict && p >= 0;
    e_ok  = reset && resolve_valid && !resolve_mispredict && p >= 0;
    e_ack = reset && take_valid && !stall && q.size() < BRAT_SIZE && !e_mis;
    e_sq = '0; e_val = '0; e_rdy = '0;
    if (e_mis) begin
      for (int i = p; i < q.size(); i++) e_sq[q[i].slot] = 1'b1;
      e_val = q[p].val;
      e_rdy = q[p].rdy | match(q[p].val, cdb_valid, cdb_tag);
    end
    chk("live_mask", 256'(live_mask), 256'(e_live));
    chk("count", 256'(count), 256'(q.size()));
    chk("full", 256'(full), 256'(q.size() == BRAT_SIZE));
    chk("take_id", 256'(take_id), 256'(mtail));
    chk("take_ack", 256'(take_ack), 256'(e_ack));
    chk("ck_write", 256'(checkpoint_write), 256'(e_mis));
    chk("ck_value", 256'(checkpoint_rat_value_out), 256'(e_val));
    chk("ck_ready", 256'(checkpoint_rat_ready_out), 256'(e_rdy));
    chk("squash", 256'(squash_mask), 256'(e_sq));
    obs_ack = take_ack; obs_take_id = take_id; obs_write = checkpoint_write;
    obs_val = checkpoint_rat_value_out; obs_rdy = checkpoint_rat_ready_out; obs_squash = squash_mask;

    if (!reset) begin
      q.delete();
      mtail = 0;
    end else begin
      e_pop = q.size() > 0 && (q[0].resolved || (e_ok && p == 0)) && !(e_mis && p == 0);
      foreach (q[i]) q[i].rdy |= match(q[i].val, cdb_valid, cdb_tag);
      if (e_ok) q[p].resolved = 1'b1;
      if (e_mis) begin
        while (q.size() > p) void'(q.pop_back());
        mtail = int'(resolve_id);
      end
      if (e_pop) void'(q.pop_front());
      if (e_ack) begin
        r.slot = mtail;
        r.val = rat_value_in;
        r.rdy = rat_ready_in | match(rat_value_in, cdb_valid, cdb_tag);
        r.resolved = 1'b0;
        q.push_back(r);
        mtail = (mtail + 1) % BRAT_SIZE;
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b0;
    cycle();
    reset = 1'b1;
  endtask

  task automatic take_n(input int n);
    for (int j = 0; j < n; j++) begin
      idle();
      take_valid = 1'b1;
      for (int i = 0; i < ARCH_REGFILE_SIZE; i++) rat_value_in[i] = PHYS_REG_TAG'(i + 8 * j);
      rat_ready_in = '1;
      cycle();
    end
    idle();
  endtask

  task automatic restore_case(input bit same_cycle);
    do_reset();
    take_valid = 1'b1;
    for (int i = 0; i < ARCH_REGFILE_SIZE; i++) rat_value_in[i] = PHYS_REG_TAG'(i);
    rat_value_in[5] = 6'd40;
    rat_ready_in = '1;
    rat_ready_in[5] = 1'b0;
    cycle();
    idle();
    cdb_valid = 1'b1; cdb_tag = 6'd40;
    if (!same_cycle) begin
      cycle();
      idle();
    end
    resolve_valid = 1'b1; resolve_id = 2'd0; resolve_mispredict = 1'b1;
    cycle();
    chk("restore_write", 256'(obs_write), 256'(1));
    chk("restore_val5", 256'(obs_val[5]), 256'(40));
    chk("restore_rdy5", 256'(obs_rdy[5]), 256'(1));
    idle();
  endtask

  initial begin
    mtail = 0;
    idle();
    reset = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b1;
    chk("rst_count", 256'(count), 256'(0));
    chk("rst_live", 256'(live_mask), 256'(0));
    chk("rst_full", 256'(full), 256'(0));

    take_n(1);
    chk("first_id", 256'(obs_take_id), 256'(0));
    chk("first_count", 256'(count), 256'(1));
    chk("first_live", 256'(live_mask), 256'(1));

    do_reset();
    take_n(5);
    chk("fill_ack5", 256'(obs_ack), 256'(0));
    chk("fill_full", 256'(full), 256'(1));
    chk("fill_count", 256'(count), 256'(4));

    restore_case(1'b0);
    restore_case(1'b1);

    do_reset();
    take_n(4);
    resolve_valid = 1'b1; resolve_id = 2'd1; resolve_mispredict = 1'b1;
    cycle();
    chk("sq_mask", 256'(obs_squash), 256'(4'b1110));
    chk("sq_val", 256'(obs_val[0]), 256'(8));
    chk("sq_count", 256'(count), 256'(1));
    take_n(1);
    chk("sq_take_id", 256'(obs_take_id), 256'(1));

    do_reset();
    take_n(4);
    resolve_valid = 1'b1; resolve_id = 2'd1;
    cycle();
    chk("res1_count", 256'(count), 256'(4));
    resolve_valid = 1'b1; resolve_id = 2'd0;
    cycle();
    chk("res0_count", 256'(count), 256'(3));
    idle();
    cycle();
    chk("res_chain_count", 256'(count), 256'(2));

    do_reset();
    take_n(1);
    take_valid = 1'b1;
    resolve_valid = 1'b1; resolve_id = 2'd0; resolve_mispredict = 1'b1;
    cycle();
    chk("mis_take_ack", 256'(obs_ack), 256'(0));
    chk("mis_take_count", 256'(count), 256'(0));
    take_n(3);
    resolve_valid = 1'b1; resolve_id = 2'd1; resolve_mispredict = 1'b1;
    reset = 1'b0;
    cycle();
    chk("midrst_write", 256'(obs_write), 256'(0));
    chk("midrst_count", 256'(count), 256'(0));

    for (int c = 0; c < 3000; c++) begin
      idle();
      reset = ($urandom_range(0, 99) != 0);
      take_valid = ($urandom_range(0, 99) < 60);
      stall = ($urandom_range(0, 99) < 15);
      for (int i = 0; i < ARCH_REGFILE_SIZE; i++) rat_value_in[i] = PHYS_REG_TAG'($urandom_range(0, 15));
      rat_ready_in = $urandom;
      resolve_valid = ($urandom_range(0, 99) < 40);
      if (q.size() > 0 && $urandom_range(0, 99) < 85)
        resolve_id = BRAT_IDX'(q[$urandom_range(0, q.size() - 1)].slot);
      else
        resolve_id = BRAT_IDX'($urandom_range(0, BRAT_SIZE - 1));
      resolve_mispredict = ($urandom_range(0, 99) < 25);
      cdb_valid = ($urandom_range(0, 99) < 50);
      cdb_tag = PHYS_REG_TAG'($urandom_range(0, 15));
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/brat_checkpoint.md
Name: brat_checkpoint

Overview:
- Branch checkpoint store (BRAT) for the rename stage.
- On branch dispatch it snapshots the RAT map and ready bits into a slot. It keeps those snapshots' ready bits current from the CDB.
- On a mispredict it drives the restore image back into the RAT's checkpoint write port and squashes that slot and every younger slot.
- Slots are kept in program order as a circular buffer. Oldest is at head. Slots are freed in order once resolved correct.

Parameters:
- BRAT_SIZE, 4, number of checkpoint slots (power of 2, ≥2).
- ARCH_REGFILE_SIZE, 32, architectural registers per snapshot (from shared package).
- PHYS_REGFILE_SIZE, 64, physical registers; tag width = $clog2(PHYS_REGFILE_SIZE).

Ports:
- clock  in  1  single clock.
- reset  in  1  synchronous, active-low; reset==0 at posedge clock resets the block.
- stall  in  1  dispatch stall; blocks snapshot take.
- take_valid  in  1  dispatching branch requests a snapshot.
- rat_value_in  in  ARCH_REGFILE_SIZE x PHYS_REG_TAG  RAT next-state map (includes this cycle's rename).
- rat_ready_in  in  ARCH_REGFILE_SIZE  RAT next-state ready bits.
- take_ack  out  1  snapshot accepted this cycle (combinational).
- take_id  out  BRAT_IDX  slot written; equals tail.
- full  out  1  count==BRAT_SIZE (registered count).
- count  out  $clog2(BRAT_SIZE)+1  live slots.
- live_mask  out  BRAT_SIZE  one-hot per live slot.
- resolve_valid  in  1  branch unit resolved a branch.
- resolve_id  in  BRAT_IDX  slot of resolved branch.
- resolve_mispredict  in  1  1 = mispredict, 0 = correct.
- cdb_valid  in  1  completion broadcast valid.
- cdb_tag  in  PHYS_REG_TAG  completing physical tag.
- checkpoint_write  out  1  restore RAT this cycle (combinational).
- checkpoint_rat_value_out  out  ARCH_REGFILE_SIZE x PHYS_REG_TAG  restore map.
- checkpoint_rat_ready_out  out  ARCH_REGFILE_SIZE  restore ready bits, CDB-forwarded.
- squash_mask  out  BRAT_SIZE  slots killed this cycle: resolve_id plus all younger live slots.

Behaviour:
Reset
- All slots invalid and unresolved; head=tail=0; count=0; full=0; live_mask=0.
- checkpoint_write, take_ack and squash_mask are forced 0 while reset==0.
- Reset mid-operation drops all snapshots with no restore.

Definitions
- mis = resolve_valid & resolve_mispredict & live[resolve_id].
- Take accept: take_ack = take_valid & ~stall & ~full & ~mis.
- No bypass of a same-cycle pop into full.

Take
- At the edge, slot[tail] gets value = rat_value_in and ready = rat_ready_in | CDB match.
- Slot becomes valid and unresolved; tail++ (wraps mod BRAT_SIZE).

CDB
- Every cycle, for every live slot and every arch reg i: if cdb_valid & value[i]==cdb_tag, set ready[i] at the edge.

Correct resolve
- resolve_valid & ~resolve_mispredict & live[resolve_id] sets resolved[resolve_id].

Pop
- At most one per cycle.
- Head pops when its resolved flag is already set, or when this cycle's correct resolve targets head.
- Pop clears the slot; head++ (wraps); count-1.

Mispredict
- Same cycle (0 latency): checkpoint_write=1 and checkpoint_rat_value_out = slot[resolve_id].value.
- checkpoint_rat_ready_out[i] = slot.ready[i] | (cdb_valid & value[i]==cdb_tag).
- squash_mask = resolve_id through tail-1 in circular order.
- At the edge: squashed slots are invalidated; tail := resolve_id; count := circular distance(head, resolve_id).
- A concurrent pop of an older head still applies (count minus 1).
- resolve_id==head leaves the buffer empty.

Simultaneous events and illegal input
- Mispredict plus take: take rejected.
- Mispredict plus CDB: CDB is forwarded into the restore image.
- Resolve of a non-live id is ignored, with a DEBUG_MODE assertion.
- When checkpoint_write=0, the checkpoint outputs are 0.

Decomposition
- Shared package holds: ARCH_REGFILE_SIZE, PHYS_REGFILE_SIZE, PHYS_REG_TAG, ARCH_REG_TAG, BRAT_SIZE, typedef BRAT_IDX, and struct BRAT_ENTRY {value array, ready array, valid, resolved}.
- One natural sub-module: brat_entry.
  - One snapshot slot: write port, CDB ready-bit update, forwarded read.
  - Instantiated BRAT_SIZE times.
  - Top level keeps head/tail/count and the age-order squash mask.

Test Plan (ARCH=32, PHYS=64, BRAT_SIZE=4):
- Reset low 1 cycle; take_valid with rat_value_in[i]=i, ready all 1 -> take_ack=1, take_id=0; next cycle count=1, live_mask=4'b0001.
- Five takes on consecutive cycles -> take_ids 0,1,2,3 acked; full=1 after the 4th; 5th take_ack=0; count stays 4.
- Slot0 holds r5->40 with ready=0; CDB tag 40 in cycle N; mispredict id0 in N+1 -> checkpoint_write=1, value[5]=40, ready[5]=1. Same stimulus with CDB and mispredict in the same cycle also gives ready[5]=1.
- 4 live slots, mispredict id1 -> squash_mask=4'b1110 and checkpoint image = slot1; next cycle count=1, tail=1; next take gets take_id=1.
- 4 live slots, resolve id1 correct -> count stays 4. Next cycle resolve id0 correct -> count 3 at that edge, then 2 on the following edge; head=2.
- Mispredict id0 with take_valid=1 in the same cycle -> take_ack=0, count=0 next cycle. Then reset=0 mid-stream with 3 live -> count=0, checkpoint_write=0.
